// File: rtl/poly_mult_pkg.sv
// -----------------------------------------------------------------------------
// poly_mult_pkg
// Purpose : shared types and helpers for the tiled polynomial multiplier
//           scheduler: the scheduler FSM state enum and tile-count helpers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package poly_mult_pkg;

   // Scheduler phases: wait for start, hand out tile pairs, wait for the
   // multiplier to return every outstanding result, then pulse done.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   // Number of tiles a polynomial of `width` coefficients splits into.
   function automatic int tile_count(input int width, input int tile);
      return width / tile;
   endfunction

   // Index width for n tiles; a single tile still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/poly_tag_fifo.sv
// -----------------------------------------------------------------------------
// poly_tag_fifo
// Purpose : small synchronous FIFO holding the C-offset tag of every tile pair
//           handed to the multiplier, so results can be labelled in order.
// Ports   : clk        - clock, rising edge
//           rst        - synchronous active-low reset (clears pointers only)
//           push       - write push_data this cycle (ignored when full)
//           push_data  - tag to store
//           pop        - discard the head entry this cycle (ignored when empty)
//           head       - oldest stored tag, combinational
//           full/empty - occupancy flags
// -----------------------------------------------------------------------------
module poly_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the slot bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[PW-1:0]];

   // Pointer bookkeeping; storage itself needs no reset because empty
   // guards every read of it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Tag storage write port.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/poly_tile_scheduler.sv
// -----------------------------------------------------------------------------
// poly_tile_scheduler
// Purpose : walks every (A tile, B tile) pair of a full polynomial product,
//           issues them to a tile multiplier with a bounded number in flight,
//           and labels each returning result with its C coefficient offset.
// Ports   : clk, rst (sync active-low)
//           start / busy / done        - product-level handshake
//           issue_valid / issue_ready  - tile pair handoff to the multiplier
//           a_tile_idx / b_tile_idx    - tile-memory read indices of the pair
//           result_valid               - multiplier produced a result
//           retire / out_base          - result retired at this C offset
//           err                        - sticky: result with nothing in flight
//           cycle_count                - busy-cycle performance counter
// Build option: define POLY_SCHED_PERF_CNT_EN to enable cycle_count; without
//           it cycle_count is tied to 0.
// -----------------------------------------------------------------------------
module poly_tile_scheduler
   import poly_mult_pkg::*;
#(
   parameter int POLY_A_WIDTH      = 16,
   parameter int POLY_B_WIDTH      = 16,
   parameter int POLY_A_TILE_WIDTH = 4,
   parameter int POLY_B_TILE_WIDTH = 4,
   parameter int MAX_INFLIGHT      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic issue_valid,
   input  logic issue_ready,
   output logic [idx_width(tile_count(POLY_A_WIDTH, POLY_A_TILE_WIDTH))-1:0] a_tile_idx,
   output logic [idx_width(tile_count(POLY_B_WIDTH, POLY_B_TILE_WIDTH))-1:0] b_tile_idx,
   input  logic result_valid,
   output logic [$clog2(POLY_A_WIDTH+POLY_B_WIDTH)-1:0] out_base,
   output logic retire,
   output logic err,
   output logic [31:0] cycle_count
);

   localparam int NA     = tile_count(POLY_A_WIDTH, POLY_A_TILE_WIDTH);
   localparam int NB     = tile_count(POLY_B_WIDTH, POLY_B_TILE_WIDTH);
   localparam int IA_W   = idx_width(NA);
   localparam int IB_W   = idx_width(NB);
   localparam int BASE_W = $clog2(POLY_A_WIDTH + POLY_B_WIDTH);
   localparam int CW     = $clog2(MAX_INFLIGHT) + 1;

   sched_state_t      state;
   sched_state_t      next_state;
   logic [CW-1:0]     inflight;
   logic              accept;
   logic              pop_ok;
   logic              last_pair;
   logic              fifo_full;
   logic              fifo_empty;
   logic [BASE_W-1:0] base_next;

   assign accept    = issue_valid && issue_ready;
   assign pop_ok    = result_valid && !fifo_empty;
   assign retire    = pop_ok;
   assign last_pair = (a_tile_idx == IA_W'(NA-1)) && (b_tile_idx == IB_W'(NB-1));
   assign base_next = BASE_W'(a_tile_idx) * BASE_W'(POLY_A_TILE_WIDTH)
                    + BASE_W'(b_tile_idx) * BASE_W'(POLY_B_TILE_WIDTH);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state logic; start outside IDLE falls through and is ignored.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ISSUE;
         ISSUE:   if (accept && last_pair) next_state = DRAIN;
         DRAIN:   if (inflight == '0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs decoded from the state; issue is throttled by the in-flight cap.
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      issue_valid = 1'b0;
      case (state)
         ISSUE: begin
            busy        = 1'b1;
            issue_valid = (inflight < CW'(MAX_INFLIGHT)) && !fifo_full;
         end
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Pair walker: A index runs fastest, B index steps when A wraps.
   always_ff @(posedge clk) begin
      if (!rst || (state == IDLE && start)) begin
         a_tile_idx <= '0;
         b_tile_idx <= '0;
      end else if (accept) begin
         if (a_tile_idx == IA_W'(NA-1)) begin
            a_tile_idx <= '0;
            b_tile_idx <= (b_tile_idx == IB_W'(NB-1)) ? '0 : b_tile_idx + IB_W'(1);
         end else begin
            a_tile_idx <= a_tile_idx + IA_W'(1);
         end
      end
   end

   // In-flight count; a simultaneous accept and retire cancel out.
   always_ff @(posedge clk) begin
      if (!rst) begin
         inflight <= '0;
      end else begin
         case ({accept, pop_ok})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // A result with no outstanding tag means the multiplier and scheduler
   // disagree; latch it until reset.
   always_ff @(posedge clk) begin
      if (!rst)                          err <= 1'b0;
      else if (result_valid && fifo_empty) err <= 1'b1;
   end

   poly_tag_fifo #(
      .DEPTH (MAX_INFLIGHT),
      .WIDTH (BASE_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (base_next),
      .pop       (pop_ok),
      .head      (out_base),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef POLY_SCHED_PERF_CNT_EN
   logic [31:0] perf_cnt;

   // Counts busy cycles of the current product and holds once done.
   always_ff @(posedge clk) begin
      if (!rst)                        perf_cnt <= '0;
      else if (state == IDLE && start) perf_cnt <= '0;
      else if (busy)                   perf_cnt <= perf_cnt + 32'd1;
   end

   assign cycle_count = perf_cnt;
`else
   assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_poly_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_poly_tile_scheduler
// Purpose : scoreboard bench for poly_tile_scheduler at default parameters.
//           Accepted pairs push their hand-computed C offset into a queue; a
//           monitor pops and compares on every result. A small reference
//           model of the product phases predicts busy/done/issue_valid/err.
// Build option: POLY_SCHED_PERF_CNT_EN selects the expected cycle_count.
// -----------------------------------------------------------------------------
module tb_poly_tile_scheduler;

   localparam int M_IDLE  = 0;
   localparam int M_ISSUE = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;
   localparam int PAIRS   = 16;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        issue_valid;
   logic        issue_ready;
   logic [1:0]  a_tile_idx;
   logic [1:0]  b_tile_idx;
   logic        result_valid;
   logic [4:0]  out_base;
   logic        retire;
   logic        err;
   logic [31:0] cycle_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // C offsets a*4 + b*4 for pairs in a-major order, worked out by hand.
   int exp_base_tbl [PAIRS] = '{0, 4, 8, 12, 4, 8, 12, 16, 8, 12, 16, 20, 12, 16, 20, 24};

   int sb_q [$];
   int due_q [$];
   int m_state = M_IDLE;
   int m_k     = 0;
   bit m_err   = 1'b0;
   int m_cc    = 0;

   int acc_count     = 0;
   int done_count    = 0;
   int overlap_count = 0;
   int busy_count    = 0;
   bit hold_results  = 1'b0;
   bit stray_req     = 1'b0;

   poly_tile_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .a_tile_idx   (a_tile_idx),
      .b_tile_idx   (b_tile_idx),
      .result_valid (result_valid),
      .out_base     (out_base),
      .retire       (retire),
      .err          (err),
      .cycle_count  (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r);
      @(posedge clk);
      #1;
      start       = s;
      issue_ready = r;
   endtask

   task automatic doReset(input int n);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic waitDone(input int limit);
      int base;
      base = done_count;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (done_count > base) break;
      end
      checkOutput("wait_done", 32'(done_count > base), 32'd1);
   endtask

   task automatic waitAccepts(input int target, input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (acc_count >= target) break;
      end
      checkOutput("wait_accepts", 32'(acc_count >= target), 32'd1);
   endtask

   task automatic clearRunCounters();
      acc_count     = 0;
      done_count    = 0;
      overlap_count = 0;
      busy_count    = 0;
   endtask

   // Multiplier stand-in: returns one result per accept three cycles later,
   // or late when held; a stray request forces a result with nothing issued.
   initial begin
      result_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stray_req) begin
            result_valid = 1'b1;
         end else if (!hold_results && due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            result_valid = 1'b1;
         end else begin
            result_valid = 1'b0;
         end
      end
   end

   // Monitor and reference model, sampled mid-cycle.
   initial begin
      forever begin
         int  n;
         bit  acc;
         bit  was_idle_start;
         bit  was_busy;
         @(negedge clk);
         n   = sb_q.size();
         acc = issue_valid && issue_ready;
         was_busy       = (m_state == M_ISSUE) || (m_state == M_DRAIN);
         was_idle_start = (m_state == M_IDLE) && start;

         checkOutput("issue_valid", 32'(issue_valid), 32'((m_state == M_ISSUE) && (n < 4)));
         checkOutput("busy", 32'(busy), 32'(was_busy));
         checkOutput("done", 32'(done), 32'(m_state == M_DONE));
         checkOutput("err", 32'(err), 32'(m_err));
         checkOutput("cycle_count", cycle_count, m_cc);
         if (done) done_count++;
         if (busy) busy_count++;

         if (result_valid) begin
            if (n > 0) begin
               checkOutput("retire", 32'(retire), 32'd1);
               checkOutput("out_base", 32'(out_base), sb_q[0]);
               void'(sb_q.pop_front());
            end else begin
               checkOutput("retire_empty", 32'(retire), 32'd0);
               m_err = 1'b1;
            end
         end else begin
            checkOutput("retire_idle", 32'(retire), 32'd0);
         end

         if (acc) begin
            if (m_state == M_ISSUE && m_k < PAIRS) begin
               checkOutput("a_tile_idx", 32'(a_tile_idx), m_k % 4);
               checkOutput("b_tile_idx", 32'(b_tile_idx), m_k / 4);
               sb_q.push_back(exp_base_tbl[m_k]);
               due_q.push_back(cyc + 3);
               if (result_valid) overlap_count++;
            end
            acc_count++;
            m_k++;
         end

`ifdef POLY_SCHED_PERF_CNT_EN
         if (was_idle_start) m_cc = 0;
         else if (was_busy)  m_cc = m_cc + 1;
`endif

         case (m_state)
            M_IDLE:  if (start) begin m_state = M_ISSUE; m_k = 0; end
            M_ISSUE: if (acc && m_k == PAIRS) m_state = M_DRAIN;
            M_DRAIN: if (n == 0) m_state = M_DONE;
            default: m_state = M_IDLE;
         endcase

         if (!rst) begin
            m_state = M_IDLE;
            m_k     = 0;
            m_err   = 1'b0;
            m_cc    = 0;
            sb_q.delete();
         end
      end
   end

   // Directed scenarios.
   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      issue_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Reset state.
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
      checkOutput("rst_retire", 32'(retire), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_a_idx", 32'(a_tile_idx), 32'd0);
      checkOutput("rst_b_idx", 32'(b_tile_idx), 32'd0);
      checkOutput("rst_cycle_count", cycle_count, 32'd0);

      // Full product, always ready, results three cycles after each accept.
      $display("[TB] full product");
      clearRunCounters();
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitDone(200);
      repeat (3) applyStimulus(1'b0, 1'b1);
      checkOutput("full_accepts", acc_count, 16);
      checkOutput("full_done_pulses", done_count, 1);
      checkOutput("full_sb_empty", sb_q.size(), 0);
      checkOutput("overlap_seen", 32'(overlap_count > 0), 32'd1);
`ifdef POLY_SCHED_PERF_CNT_EN
      checkOutput("perf_total", cycle_count, busy_count);
`else
      checkOutput("perf_tied", cycle_count, 32'd0);
`endif

      // Back-pressure: ready low for five cycles after the sixth accept.
      $display("[TB] back-pressure");
      clearRunCounters();
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitAccepts(6, 50);
      issue_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_issue_valid", 32'(issue_valid), 32'd1);
         checkOutput("bp_a_idx", 32'(a_tile_idx), 32'd2);
         checkOutput("bp_b_idx", 32'(b_tile_idx), 32'd1);
         @(posedge clk);
         #1;
      end
      issue_ready = 1'b1;
      waitDone(200);
      repeat (3) applyStimulus(1'b0, 1'b1);
      checkOutput("bp_accepts", acc_count, 16);
      checkOutput("bp_done_pulses", done_count, 1);

      // Results withheld: issue stops at the in-flight cap, then resumes.
      $display("[TB] results withheld");
      clearRunCounters();
      hold_results = 1'b1;
      applyStimulus(1'b1, 1'b1);
      repeat (10) applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("stall_accepts", acc_count, 4);
      checkOutput("stall_issue_valid", 32'(issue_valid), 32'd0);
      @(posedge clk);
      #1;
      hold_results = 1'b0;
      waitDone(300);
      repeat (3) applyStimulus(1'b0, 1'b1);
      checkOutput("stall_accepts_total", acc_count, 16);

      // Second start while busy is ignored.
      $display("[TB] start while busy");
      clearRunCounters();
      applyStimulus(1'b1, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitDone(200);
      repeat (4) applyStimulus(1'b0, 1'b1);
      checkOutput("dup_start_accepts", acc_count, 16);
      checkOutput("dup_start_done_pulses", done_count, 1);
      checkOutput("dup_start_busy", 32'(busy), 32'd0);

      // Stray result in IDLE sets a sticky err.
      $display("[TB] stray result");
      @(negedge clk);
      stray_req = 1'b1;
      @(negedge clk);
      stray_req = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("stray_err", 32'(err), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("stray_err_sticky", 32'(err), 32'd1);
      doReset(1);
      @(negedge clk);
      checkOutput("stray_err_cleared", 32'(err), 32'd0);

      // Reset in the middle of issuing.
      $display("[TB] reset mid-issue");
      clearRunCounters();
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitAccepts(5, 50);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_busy", 32'(busy), 32'd0);
      checkOutput("mid_done", 32'(done), 32'd0);
      checkOutput("mid_issue_valid", 32'(issue_valid), 32'd0);
      checkOutput("mid_retire", 32'(retire), 32'd0);
      checkOutput("mid_a_idx", 32'(a_tile_idx), 32'd0);
      checkOutput("mid_b_idx", 32'(b_tile_idx), 32'd0);
      checkOutput("mid_cycle_count", cycle_count, 32'd0);
      repeat (6) @(negedge clk);
      checkOutput("late_result_err", 32'(err), 32'd1);
      repeat (10) @(negedge clk);
      doReset(2);
      @(negedge clk);
      checkOutput("final_err", 32'(err), 32'd0);
      checkOutput("final_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net against a hung run.
   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/poly_tile_scheduler.md
POLY_TILE_SCHEDULER -- requirements
Module: poly_tile_scheduler

Interface
REQ-001 SHALL have parameter POLY_A_WIDTH, default 16, meaning coefficients in polynomial A.
REQ-002 SHALL have parameter POLY_B_WIDTH, default 16, meaning coefficients in polynomial B.
REQ-003 SHALL have parameter POLY_A_TILE_WIDTH, default 4, meaning coefficients per A tile; must divide POLY_A_WIDTH.
REQ-004 SHALL have parameter POLY_B_TILE_WIDTH, default 4, meaning coefficients per B tile; must divide POLY_B_WIDTH.
REQ-005 SHALL have parameter MAX_INFLIGHT, default 4, meaning the limit on issued, unretired tile pairs; power of two, at least 2.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL provide port start, input, 1 bit: a one-cycle request to begin a full product.
REQ-009 SHALL provide port busy, output, 1 bit: high from accepted start until done.
REQ-010 SHALL provide port done, output, 1 bit: a one-cycle pulse when the last result retires.
REQ-011 SHALL provide port issue_valid, output, 1 bit: drives the multiplier inputs_ready_signal.
REQ-012 SHALL provide port issue_ready, input, 1 bit: the multiplier can accept a tile pair.
REQ-013 SHALL provide ports a_tile_idx and b_tile_idx, outputs, $clog2(NA) and $clog2(NB) bits (min 1): tile-memory read indices for the issued pair.
REQ-014 SHALL provide port result_valid, input, 1 bit: the multiplier outputs_ready_signal.
REQ-015 SHALL provide port out_base, output, $clog2(POLY_A_WIDTH+POLY_B_WIDTH) bits: C coefficient offset of the retiring result, valid with retire.
REQ-016 SHALL provide port retire, output, 1 bit: out_base is valid this cycle.
REQ-017 SHALL provide port err, output, 1 bit: sticky protocol error.
REQ-018 SHALL provide port cycle_count, output, 32 bits: performance counter (see Configuration).

Function
REQ-019 SHALL define NA = POLY_A_WIDTH/POLY_A_TILE_WIDTH and NB = POLY_B_WIDTH/POLY_B_TILE_WIDTH; the total number of pairs is NA*NB.
REQ-020 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE: IDLE->ISSUE on start; ISSUE->DRAIN on acceptance of the last pair; DRAIN->DONE when the in-flight count reaches 0; DONE->IDLE after 1 cycle.
REQ-021 SHALL ignore start whenever the FSM is not in IDLE.
REQ-022 SHALL issue pairs in a-major order (a_tile_idx increments fastest, wraps to 0, then b_tile_idx increments); indices are registered outputs.
REQ-023 SHALL treat a pair as accepted in a cycle where issue_valid and issue_ready are both high; indices then advance on the next edge.
REQ-024 SHALL assert issue_valid only in ISSUE with in-flight count < MAX_INFLIGHT, and hold it with stable indices until accepted.
REQ-025 SHALL push out_base = a_idx*POLY_A_TILE_WIDTH + b_idx*POLY_B_TILE_WIDTH into a MAX_INFLIGHT-deep tag FIFO on each accept.
REQ-026 SHALL, on result_valid, pop the FIFO head onto out_base and assert retire in the same cycle (combinational from the head).
REQ-027 SHALL leave the in-flight count unchanged when accept and result_valid occur in the same cycle, with FIFO push and pop both performed.
REQ-028 SHALL set err on result_valid while the FIFO is empty, take no pop, and hold err until reset.
REQ-029 SHALL assert done in DONE only; busy is high in ISSUE and DRAIN.

Reset
REQ-030 SHALL, with rst low at a clock edge, go to IDLE, clear indices, in-flight count, FIFO pointers, err and cycle_count, and drive busy, done, issue_valid and retire to 0, including mid-operation; in-flight results arriving after reset SHALL set err.

Configuration
REQ-031 SHALL, with POLY_SCHED_PERF_CNT_EN defined, have cycle_count clear on accepted start, increment every cycle while busy, and hold its value after done.
REQ-032 SHALL, without POLY_SCHED_PERF_CNT_EN, tie cycle_count to 0 and omit the counter logic.

Structure
REQ-033 SHALL place the FSM state enum and a tile-count helper function in the shared package poly_mult_pkg.
REQ-034 SHALL implement the tag FIFO as sub-module poly_tag_fifo (parameters depth and width; push, pop, full, empty).

Verification
REQ-035 SHALL verify the defaults, start with issue_ready=1 and result_valid 3 cycles after each accept: 16 accepts, first 4 pair indices (0,0),(1,0),(2,0),(3,0), the out_base sequence 0,4,8,12,4,..., and one done pulse.
REQ-036 SHALL verify back-pressure, issue_ready=0 for 5 cycles mid-run: issue_valid held with constant indices, and no lost or duplicated pairs.
REQ-037 SHALL verify no results for 10 cycles: exactly 4 accepts then issue_valid=0; resuming results resumes issue.
REQ-038 SHALL verify simultaneous accept and result_valid: in-flight count unchanged and retire order equal to accept order.
REQ-039 SHALL verify a stray result_valid in IDLE -> err=1 until rst, and a second start while busy -> ignored.
REQ-040 SHALL verify rst low mid-ISSUE -> all outputs 0 the next cycle; with POLY_SCHED_PERF_CNT_EN, cycle_count equals the cycles from start to done.
